// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration loader and its chain bench.
// Word width, FSM state type and the running checksum helper.
package cfg_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK
    } state_t;

    function automatic logic [WORD_W-1:0] xor_acc(
        input logic [WORD_W-1:0] acc,
        input logic [WORD_W-1:0] w
    );
        return acc ^ w;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Streams WORDS configuration words into a shift chain, then checks a
// trailing checksum word and accumulates the chain's old contents.
module prog_loader
    import cfg_pkg::*;
#(
    parameter int WORDS = 75
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] prog_data,
    output logic              prog_shft,
    input  logic [WORD_W-1:0] chain_i,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [WORD_W-1:0] rb_sum,
    output logic [10:0]       count
);

    localparam logic [10:0] LAST = 11'(WORDS - 1);

    state_t            state;
    logic [WORD_W-1:0] in_sum;
    logic              xfer;

    assign xfer = s_valid & s_ready;

    // Load FSM: forwards data words, tracks both checksums, checks the tail.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state     <= IDLE;
            s_ready   <= 1'b0;
            prog_data <= '0;
            prog_shft <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rb_sum    <= '0;
            count     <= '0;
            in_sum    <= '0;
        end else begin
            done      <= 1'b0;
            prog_shft <= 1'b0;
            if (prog_shft) begin
                rb_sum <= xor_acc(rb_sum, chain_i);
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
                        count   <= '0;
                        in_sum  <= '0;
                        rb_sum  <= '0;
                        err     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        prog_data <= s_data;
                        prog_shft <= 1'b1;
                        count     <= count + 11'd1;
                        in_sum    <= xor_acc(in_sum, s_data);
                        if (count == LAST) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        state   <= IDLE;
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err     <= (s_data != in_sum);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader with an external shift-chain model
// and a word-level reference of the expected loader outputs.
module tb_prog_loader;
    import cfg_pkg::*;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        start = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] prog_data;
    logic        prog_shft;
    logic [31:0] chain_i;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rb_sum;
    logic [10:0] count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    prog_loader #(.WORDS(W)) dut (
        .clk       (clk),
        .res       (res),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .prog_data (prog_data),
        .prog_shft (prog_shft),
        .chain_i   (chain_i),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rb_sum    (rb_sum),
        .count     (count)
    );

    // External configuration chain: stage 0 takes prog_data on a shift.
    logic [31:0] chain [W];
    logic        preload_req = 1'b1;
    assign chain_i = chain[W-1];

    always @(posedge clk) begin
        if (preload_req) begin
            chain[0] <= 32'hA;
            chain[1] <= 32'hB;
            chain[2] <= 32'hC;
            chain[3] <= 32'hD;
        end else if (prog_shft) begin
            for (int i = W - 1; i > 0; i--) chain[i] <= chain[i-1];
            chain[0] <= prog_data;
        end
    end

    // Reference: word-level view of a load transaction.
    logic        m_busy = 0;
    logic        m_shft = 0;
    logic        m_done = 0;
    logic        m_err = 0;
    logic [31:0] m_pdata = 0;
    logic [31:0] m_rb = 0;
    logic [31:0] m_xs = 0;
    int          m_n = 0;
    int          m_nsh = 0;
    logic [31:0] snap [W];

    always @(posedge clk or posedge res) begin
        if (res) begin
            m_busy = 0; m_shft = 0; m_done = 0; m_err = 0;
            m_pdata = 0; m_rb = 0; m_xs = 0; m_n = 0; m_nsh = 0;
        end else begin
            if (m_shft && m_nsh < W) begin
                m_rb = m_rb ^ snap[W-1-m_nsh];
                m_nsh++;
            end
            m_shft = 0;
            m_done = 0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_n = 0; m_xs = 0; m_rb = 0;
                    m_err = 0; m_nsh = 0;
                    for (int i = 0; i < W; i++) snap[i] = chain[i];
                end
            end else if (s_valid) begin
                if (m_n < W) begin
                    m_pdata = s_data;
                    m_shft = 1;
                    m_n++;
                    m_xs = m_xs ^ s_data;
                end else begin
                    m_err = (s_data != m_xs);
                    m_done = 1;
                    m_busy = 0;
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t actual=%h required=%h",
                     name, $time, act, exp);
        end
    endtask

    int          done_cnt = 0;
    logic [31:0] shq[$];
    int          sh_first = -1;
    int          sh_last = -1;
    int          cyc = 0;

    // Per-cycle compare of every registered output against the reference.
    always @(negedge clk) begin
        cyc++;
        chk("s_ready", 32'(s_ready), 32'(m_busy));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("prog_shft", 32'(prog_shft), 32'(m_shft));
        chk("prog_data", prog_data, m_pdata);
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
        chk("rb_sum", rb_sum, m_rb);
        chk("count", 32'(count), 32'(m_n));
        if (done) done_cnt++;
        if (prog_shft) begin
            shq.push_back(prog_data);
            if (sh_first < 0) sh_first = cyc;
            sh_last = cyc;
        end
    end

    task automatic send(logic [31:0] d, bit st);
        logic rdy;
        bit   ok;
        ok = 0;
        s_valid = 1;
        s_data = d;
        start = st;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk) rdy = s_ready;
            @(posedge clk);
            #1 start = 0;
            if (rdy) ok = 1;
        end
        chk("xfer_bound", 32'(ok), 32'd1);
        s_valid = 0;
    endtask

    task automatic do_load(logic [31:0] w [W], logic [31:0] csum,
                           int gap_at, int gap_len, bit st_mid);
        done_cnt = 0;
        shq.delete();
        sh_first = -1;
        sh_last = -1;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        for (int i = 0; i < W; i++) begin
            if (i == gap_at) begin
                s_valid = 0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
            send(w[i], st_mid && i == 1);
        end
        send(csum, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("done_pulses", 32'(done_cnt), 32'd1);
        for (int i = 0; i < W; i++)
            chk("chain_word", chain[i], w[W-1-i]);
    endtask

    logic [31:0] wv [W];
    logic [31:0] cs;

    initial begin
        repeat (2) @(posedge clk);
        #1 preload_req = 0;
        res = 0;
        repeat (2) @(posedge clk);
        #1;
        wv = '{32'd1, 32'd2, 32'd3, 32'd4};

        // Back-to-back load of 1..4 over a chain preloaded with A..D.
        do_load(wv, 32'd4, -1, 0, 0);
        chk("b2b_shft_count", 32'(shq.size()), 32'd4);
        for (int i = 0; i < shq.size() && i < 4; i++)
            chk("b2b_shft_word", shq[i], 32'(i + 1));
        chk("b2b_contiguous", 32'(sh_last - sh_first), 32'd3);
        chk("b2b_err", 32'(err), 32'd0);
        chk("abcd_rb_sum", rb_sum, 32'h0);

        // Bad checksum: err held until the next start.
        do_load(wv, 32'd5, -1, 0, 0);
        chk("bad_err", 32'(err), 32'd1);
        chk("prev_chain_rb", rb_sum, 32'h4);
        repeat (3) @(posedge clk);
        #1 chk("err_held", 32'(err), 32'd1);

        // Three-cycle stall between words 2 and 3.
        do_load(wv, 32'd4, 2, 3, 0);
        chk("gap_shft_count", 32'(shq.size()), 32'd4);
        chk("gap_err", 32'(err), 32'd0);
        chk("gap_chain0", chain[0], 32'd4);
        chk("gap_chain3", chain[3], 32'd1);

        // Start pulsed mid-load has no effect.
        do_load(wv, 32'd4, -1, 0, 1);
        chk("stmid_err", 32'(err), 32'd0);

        // Reset after word 2, then a fresh complete load.
        start = 1;
        @(posedge clk);
        #1 start = 0;
        send(32'd1, 0);
        send(32'd2, 0);
        res = 1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rb", rb_sum, 32'd0);
        chk("rst_pdata", prog_data, 32'd0);
        @(posedge clk);
        #1 res = 0;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        chk("restart_count", 32'(count), 32'd0);
        res = 1;
        @(posedge clk);
        #1 res = 0;
        do_load(wv, 32'd4, -1, 0, 0);
        chk("post_rst_err", 32'(err), 32'd0);
        chk("post_rst_count", 32'(count), 32'd4);

        // Randomised loads.
        for (int t = 0; t < 25; t++) begin
            cs = 0;
            for (int i = 0; i < W; i++) begin
                wv[i] = $urandom;
                cs = cs ^ wv[i];
            end
            if ($urandom_range(0, 1) == 1) cs = cs ^ (32'd1 << $urandom_range(0, 31));
            do_load(wv, cs, int'($urandom_range(0, W)),
                    int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: WORDS, 75, number of 32-bit configuration words in the target shift chain (range 1..1024).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 res  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin a load; sampled only in IDLE.
REQ-005 s_data  input  32  configuration word stream.
REQ-006 s_valid  input  1  s_data valid.
REQ-007 s_ready  output  1  loader accepts s_data; transfer occurs when s_valid and s_ready are both high on a rising edge.
REQ-008 prog_data  output  32  word driven into the chain's first stage (prog_i).
REQ-009 prog_shft  output  1  chain shift enable; high only for cycles carrying a valid word.
REQ-010 chain_i  input  32  chain's last-stage output (prog_o), used for readback.
REQ-011 busy  output  1  high in LOAD and CHECK.
REQ-012 done  output  1  one-cycle pulse on load completion.
REQ-013 err  output  1  checksum mismatch flag.
REQ-014 rb_sum  output  32  XOR of all words shifted out of the chain during the last load.
REQ-015 count  output  11  data words accepted in the current load.

Function
REQ-016 FSM states are IDLE, LOAD and CHECK.
REQ-017 IDLE: s_ready=0 and prog_shft=0; start=1 -> LOAD, clearing count, the input checksum, rb_sum and err.
REQ-018 LOAD: s_ready=1; each transfer sets prog_data<=s_data and prog_shft<=1 at the same edge, increments count and XORs s_data into the input checksum.
REQ-019 prog_shft SHALL be 0 on every edge that follows a cycle with no transfer; a stalled stream (s_valid=0) never shifts the chain.
REQ-020 The transfer that makes count equal WORDS -> CHECK; no further word is forwarded to prog_data.
REQ-021 CHECK: s_ready=1; the next transfer is the checksum word, compared with the XOR of all WORDS data words; prog_shft stays 0.
REQ-022 CHECK transfer -> IDLE with done=1 for exactly one cycle; err is set on mismatch and held until the next start or reset.
REQ-023 On every edge where prog_shft=1, rb_sum<=rb_sum^chain_i, so rb_sum equals the XOR of the previous configuration after WORDS shifts.
REQ-024 Latency: word k accepted at edge t appears on prog_data with prog_shft=1 after edge t and enters chain stage 0 at edge t+1.
REQ-025 start while busy is ignored; s_valid in IDLE is ignored and s_ready stays 0.
REQ-026 Back-to-back transfers sustain one word per cycle, with prog_shft continuously high.
REQ-027 count saturates at WORDS and never wraps.

Reset
REQ-028 res=1 forces IDLE immediately, regardless of clock.
REQ-029 Under reset: prog_data=0, prog_shft=0, s_ready=0, busy=0, done=0, err=0, rb_sum=0, count=0.
REQ-030 Reset mid-LOAD discards the partial load; the chain holds a partial shift, and the next start restarts from word 0.

Structure
REQ-031 A shared package cfg_pkg SHALL hold WORD_W=32, the state enum type, and the XOR checksum function for reuse by the chain testbench.
REQ-032 The design SHALL be flat with no sub-module; the FSM, counter and both accumulators reside in prog_loader.
REQ-033 All outputs SHALL be registered.

Verification
REQ-034 WORDS=4, words 1,2,3,4 with checksum 4, back-to-back -> prog_shft high 4 consecutive cycles carrying 1..4, done pulse, err=0.
REQ-035 Same words with checksum 5 -> done pulse, err=1 until the next start.
REQ-036 s_valid low for 3 cycles between words 2 and 3 -> prog_shft=0 during the gap; chain contents identical to the back-to-back case.
REQ-037 Chain model preloaded with 0xA,0xB,0xC,0xD, then a full load -> rb_sum=0xA^0xB^0xC^0xD=0x0.
REQ-038 res pulsed after word 2, then a fresh start and 4 words -> all outputs hold reset values during res, count restarts at 0, load completes normally.
REQ-039 start pulsed during LOAD -> no effect on count, state or outputs.
